// File: rtl/flowstate_tx_update_wb_pkg.sv
// Shared definitions for the flowstate tx update/write-back stage:
// bus widths, flowstate field positions and match_sel encodings.
package flowstate_tx_update_wb_pkg;

  localparam int PKT_METADATA_WIDTH = 274;
  localparam int FLOWSTATE_WIDTH    = 33;
  localparam int ADDR_WIDTH         = 10;
  localparam int PKT_PROPERTY_NO    = 246;

  localparam int FS_VALID_BIT  = 32;
  localparam int PSN_WIDTH     = 32;
  localparam int DAT_TAG_INDEX = 0;
  localparam int HIST_DEPTH    = 3;

  typedef enum logic [1:0] {
    SEL_MAT   = 2'd0,
    SEL_HIST0 = 2'd1,
    SEL_HIST1 = 2'd2,
    SEL_HIST2 = 2'd3
  } match_sel_e;

  function automatic logic [FLOWSTATE_WIDTH-1:0] fs_pack(input logic [PSN_WIDTH-1:0] psn);
    return {1'b1, psn};
  endfunction

endpackage

// File: rtl/flowstate_tx_update_wb_if.sv
// Handshake bundle between the address controller, this stage, the flowstate
// table write port and the downstream consumer.
interface flowstate_tx_update_wb_if;
  import flowstate_tx_update_wb_pkg::*;

  logic [PKT_METADATA_WIDTH-1:0] s_pkt_metadata_info;
  logic [1:0]                    s_pkt_metadata_match_sel;
  logic                          s_pkt_metadata_mat_hit;
  logic [FLOWSTATE_WIDTH-1:0]    s_pkt_metadata_mat_value;
  logic [ADDR_WIDTH-1:0]         s_pkt_metadata_mat_addr;
  logic                          s_pkt_metadata_valid;
  logic                          s_pkt_metadata_ready;

  logic                          m_flowstate_wr_en;
  logic [ADDR_WIDTH-1:0]         m_flowstate_wr_addr;
  logic [FLOWSTATE_WIDTH-1:0]    m_flowstate_wr_data;

  logic [PKT_METADATA_WIDTH-1:0] m_pkt_metadata_info;
  logic [PSN_WIDTH-1:0]          m_pkt_metadata_psn;
  logic                          m_pkt_metadata_psn_valid;
  logic                          m_pkt_metadata_valid;
  logic                          m_pkt_metadata_ready;

  modport slave (
    input  s_pkt_metadata_info, s_pkt_metadata_match_sel, s_pkt_metadata_mat_hit,
           s_pkt_metadata_mat_value, s_pkt_metadata_mat_addr, s_pkt_metadata_valid,
           m_pkt_metadata_ready,
    output s_pkt_metadata_ready, m_flowstate_wr_en, m_flowstate_wr_addr,
           m_flowstate_wr_data, m_pkt_metadata_info, m_pkt_metadata_psn,
           m_pkt_metadata_psn_valid, m_pkt_metadata_valid
  );

  modport master (
    output s_pkt_metadata_info, s_pkt_metadata_match_sel, s_pkt_metadata_mat_hit,
           s_pkt_metadata_mat_value, s_pkt_metadata_mat_addr, s_pkt_metadata_valid,
           m_pkt_metadata_ready,
    input  s_pkt_metadata_ready, m_flowstate_wr_en, m_flowstate_wr_addr,
           m_flowstate_wr_data, m_pkt_metadata_info, m_pkt_metadata_psn,
           m_pkt_metadata_psn_valid, m_pkt_metadata_valid
  );

endinterface

// File: rtl/flowstate_tx_update_wb_history.sv
// 3-entry write history (entry 0 newest) with a combinational select port,
// used to forward freshly written flowstate ahead of the table RAM.
module flowstate_wb_history
  import flowstate_tx_update_wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 push_valid,
  input  logic [PSN_WIDTH-1:0] push_psn,
  input  match_sel_e           sel,
  output logic                 sel_valid,
  output logic [PSN_WIDTH-1:0] sel_psn
);

  logic [HIST_DEPTH-1:0] hist_vld;
  logic [PSN_WIDTH-1:0]  hist_psn [HIST_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld <= '0;
    end else if (push) begin
      hist_vld <= {hist_vld[HIST_DEPTH-2:0], push_valid};
    end
  end

  // Payload needs no reset: it is only ever consumed behind its valid bit.
  always_ff @(posedge clk) begin
    if (push) begin
      hist_psn[0] <= push_psn;
      hist_psn[1] <= hist_psn[0];
      hist_psn[2] <= hist_psn[1];
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_psn   = hist_psn[0];
    case (sel)
      SEL_HIST0: begin sel_valid = hist_vld[0]; sel_psn = hist_psn[0]; end
      SEL_HIST1: begin sel_valid = hist_vld[1]; sel_psn = hist_psn[1]; end
      SEL_HIST2: begin sel_valid = hist_vld[2]; sel_psn = hist_psn[2]; end
      default:   begin sel_valid = 1'b0;        sel_psn = hist_psn[0]; end
    endcase
  end

endmodule

// File: rtl/flowstate_tx_update_wb.sv
// Flowstate write-back stage: assigns PSN, writes incremented flowstate back,
// forwards from own history. Optional counters under FLOWSTATE_WB_STATS_EN.
module flowstate_tx_update_wb
  import flowstate_tx_update_wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  flowstate_tx_update_wb_if.slave bus
`ifdef FLOWSTATE_WB_STATS_EN
  ,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_fwd_cnt,
  output logic [31:0] stat_fwd_err_cnt
`endif
);

  logic                          accept;
  logic                          do_write;
  logic                          use_fwd;
  logic                          fwd_valid;
  logic [PSN_WIDTH-1:0]          fwd_psn;
  logic [PSN_WIDTH-1:0]          old_psn;
  logic [PSN_WIDTH-1:0]          new_psn;
  match_sel_e                    sel;
  logic                          unused_mat_flow_valid;

  logic                          m_valid_q;
  logic                          wr_en_q;
  logic [ADDR_WIDTH-1:0]         wr_addr_q;
  logic [FLOWSTATE_WIDTH-1:0]    wr_data_q;
  logic [PSN_WIDTH-1:0]          psn_q;
  logic                          psn_valid_q;
  logic [PKT_METADATA_WIDTH-1:0] info_q;

  assign sel      = match_sel_e'(bus.s_pkt_metadata_match_sel);
  assign bus.s_pkt_metadata_ready = ~m_valid_q | bus.m_pkt_metadata_ready;
  assign accept   = bus.s_pkt_metadata_valid & bus.s_pkt_metadata_ready;
  assign do_write = bus.s_pkt_metadata_mat_hit &
                    bus.s_pkt_metadata_info[PKT_PROPERTY_NO + DAT_TAG_INDEX];

  // Invalid history entry falls back to the table value.
  assign use_fwd  = (sel != SEL_MAT) & fwd_valid;
  assign old_psn  = use_fwd ? fwd_psn : bus.s_pkt_metadata_mat_value[PSN_WIDTH-1:0];
  assign new_psn  = old_psn + 32'd1;
  assign unused_mat_flow_valid = bus.s_pkt_metadata_mat_value[FS_VALID_BIT];

  flowstate_wb_history u_history (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_valid (do_write),
    .push_psn   (new_psn),
    .sel        (sel),
    .sel_valid  (fwd_valid),
    .sel_psn    (fwd_psn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      psn_q       <= '0;
      psn_valid_q <= 1'b0;
    end else begin
      wr_en_q <= accept & do_write;
      if (accept & do_write) begin
        wr_addr_q <= bus.s_pkt_metadata_mat_addr;
        wr_data_q <= fs_pack(new_psn);
      end
      if (accept) begin
        m_valid_q   <= 1'b1;
        psn_q       <= old_psn;
        psn_valid_q <= do_write;
      end else if (bus.m_pkt_metadata_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) info_q <= bus.s_pkt_metadata_info;
  end

  assign bus.m_flowstate_wr_en        = wr_en_q;
  assign bus.m_flowstate_wr_addr      = wr_addr_q;
  assign bus.m_flowstate_wr_data      = wr_data_q;
  assign bus.m_pkt_metadata_info      = info_q;
  assign bus.m_pkt_metadata_psn       = psn_q;
  assign bus.m_pkt_metadata_psn_valid = psn_valid_q;
  assign bus.m_pkt_metadata_valid     = m_valid_q;

`ifdef FLOWSTATE_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_cnt      <= '0;
      stat_fwd_cnt     <= '0;
      stat_fwd_err_cnt <= '0;
    end else begin
      if (accept & do_write & (stat_wr_cnt != '1))
        stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (accept & use_fwd & (stat_fwd_cnt != '1))
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      if (accept & (sel != SEL_MAT) & ~fwd_valid & (stat_fwd_err_cnt != '1))
        stat_fwd_err_cnt <= stat_fwd_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flowstate_tx_update_wb.sv
// Directed bench for flowstate_tx_update_wb: PSN assignment, write-back,
// history forwarding, wrap, fallback, backpressure and mid-stream reset.
module tb_flowstate_tx_update_wb;
  import flowstate_tx_update_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  flowstate_tx_update_wb_if bus ();

`ifdef FLOWSTATE_WB_STATS_EN
  logic [31:0] stat_wr_cnt, stat_fwd_cnt, stat_fwd_err_cnt;
`endif

  flowstate_tx_update_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FLOWSTATE_WB_STATS_EN
    ,
    .stat_wr_cnt      (stat_wr_cnt),
    .stat_fwd_cnt     (stat_fwd_cnt),
    .stat_fwd_err_cnt (stat_fwd_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hit, input logic dat, input logic [1:0] sel,
                       input logic [32:0] val, input logic [9:0] addr,
                       input logic [15:0] tag);
    logic [PKT_METADATA_WIDTH-1:0] info;
    info = '0;
    info[15:0] = tag;
    info[PKT_PROPERTY_NO] = dat;
    bus.s_pkt_metadata_info      = info;
    bus.s_pkt_metadata_mat_hit   = hit;
    bus.s_pkt_metadata_match_sel = sel;
    bus.s_pkt_metadata_mat_value = val;
    bus.s_pkt_metadata_mat_addr  = addr;
    bus.s_pkt_metadata_valid     = 1'b1;
  endtask

  task automatic idle();
    bus.s_pkt_metadata_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    bus.m_pkt_metadata_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.m_pkt_metadata_valid !== 1'b0 || bus.m_flowstate_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: m_valid=%b wr_en=%b required 0/0",
               bus.m_pkt_metadata_valid, bus.m_flowstate_wr_en);
    end
    checks++;
    if (bus.m_flowstate_wr_addr !== 10'h0 || bus.m_flowstate_wr_data !== 33'h0) begin
      errors++;
      $display("FAIL reset_wr: addr=%h data=%h required 0/0",
               bus.m_flowstate_wr_addr, bus.m_flowstate_wr_data);
    end
    checks++;
    if (bus.m_pkt_metadata_psn !== 32'h0 || bus.m_pkt_metadata_psn_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_psn: psn=%h psn_valid=%b required 0/0",
               bus.m_pkt_metadata_psn, bus.m_pkt_metadata_psn_valid);
    end
    checks++;
    if (bus.s_pkt_metadata_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready: got %b required 1", bus.s_pkt_metadata_ready);
    end
  endtask

  task automatic test_single();
    logic [PKT_METADATA_WIDTH-1:0] exp_info;
    drive(1'b1, 1'b1, 2'd0, 33'h1_0000_0005, 10'h010, 16'hA001);
    exp_info = bus.s_pkt_metadata_info;
    tick();
    idle();
    checks++;
    if (bus.m_pkt_metadata_valid !== 1'b1 || bus.m_pkt_metadata_psn !== 32'h5 ||
        bus.m_pkt_metadata_psn_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_out: m_valid=%b psn=%h psn_valid=%b required 1/5/1",
               bus.m_pkt_metadata_valid, bus.m_pkt_metadata_psn, bus.m_pkt_metadata_psn_valid);
    end
    checks++;
    if (bus.m_flowstate_wr_en !== 1'b1 || bus.m_flowstate_wr_addr !== 10'h010 ||
        bus.m_flowstate_wr_data !== 33'h1_0000_0006) begin
      errors++;
      $display("FAIL single_wr: en=%b addr=%h data=%h required 1/010/100000006",
               bus.m_flowstate_wr_en, bus.m_flowstate_wr_addr, bus.m_flowstate_wr_data);
    end
    checks++;
    if (bus.m_pkt_metadata_info !== exp_info) begin
      errors++;
      $display("FAIL single_info: tag got %h required %h",
               bus.m_pkt_metadata_info[15:0], exp_info[15:0]);
    end
    tick();
    checks++;
    if (bus.m_flowstate_wr_en !== 1'b0 || bus.m_pkt_metadata_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: wr_en=%b m_valid=%b required 0/0",
               bus.m_flowstate_wr_en, bus.m_pkt_metadata_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_psn [3] = '{32'h5, 32'h6, 32'h7};
    logic [1:0]  sel_v   [3] = '{2'd0, 2'd1, 2'd1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, sel_v[i], 33'h1_0000_0005, 10'h010, 16'hB000 + 16'(i));
      tick();
      checks++;
      if (bus.m_pkt_metadata_valid !== 1'b1 || bus.m_pkt_metadata_psn !== exp_psn[i] ||
          bus.m_flowstate_wr_en !== 1'b1 ||
          bus.m_flowstate_wr_data !== {1'b1, exp_psn[i] + 32'd1}) begin
        errors++;
        $display("FAIL b2b_%0d: m_valid=%b psn=%h wr_en=%b wr_data=%h required 1/%h/1/%h",
                 i, bus.m_pkt_metadata_valid, bus.m_pkt_metadata_psn, bus.m_flowstate_wr_en,
                 bus.m_flowstate_wr_data, exp_psn[i], {1'b1, exp_psn[i] + 32'd1});
      end
    end
    idle();
    tick();
`ifdef FLOWSTATE_WB_STATS_EN
    checks++;
    if (stat_wr_cnt !== 32'd3 || stat_fwd_cnt !== 32'd2 || stat_fwd_err_cnt !== 32'd0) begin
      errors++;
      $display("FAIL b2b_stats: wr=%0d fwd=%0d err=%0d required 3/2/0",
               stat_wr_cnt, stat_fwd_cnt, stat_fwd_err_cnt);
    end
`endif
  endtask

  task automatic test_depth3();
    drive(1'b1, 1'b1, 2'd0, 33'h1_0000_0010, 10'h020, 16'hC000);
    tick();
    drive(1'b1, 1'b1, 2'd0, 33'h1_0000_0100, 10'h021, 16'hC001);
    tick();
    drive(1'b1, 1'b1, 2'd0, 33'h1_0000_0200, 10'h022, 16'hC002);
    tick();
    drive(1'b1, 1'b1, 2'd3, 33'h1_0000_0010, 10'h020, 16'hC003);
    tick();
    idle();
    checks++;
    if (bus.m_pkt_metadata_psn !== 32'h11 || bus.m_flowstate_wr_addr !== 10'h020 ||
        bus.m_flowstate_wr_data !== 33'h1_0000_0012) begin
      errors++;
      $display("FAIL depth3_fwd: psn=%h addr=%h data=%h required 11/020/100000012",
               bus.m_pkt_metadata_psn, bus.m_flowstate_wr_addr, bus.m_flowstate_wr_data);
    end
    tick();
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 2'd0, 33'h1_FFFF_FFFF, 10'h3FF, 16'hD000);
    tick();
    checks++;
    if (bus.m_pkt_metadata_psn !== 32'hFFFF_FFFF || bus.m_flowstate_wr_data !== 33'h1_0000_0000) begin
      errors++;
      $display("FAIL wrap: psn=%h data=%h required ffffffff/100000000",
               bus.m_pkt_metadata_psn, bus.m_flowstate_wr_data);
    end
    drive(1'b1, 1'b1, 2'd1, 33'h1_FFFF_FFFF, 10'h3FF, 16'hD001);
    tick();
    idle();
    checks++;
    if (bus.m_pkt_metadata_psn !== 32'h0 || bus.m_flowstate_wr_data !== 33'h1_0000_0001) begin
      errors++;
      $display("FAIL wrap_fwd: psn=%h data=%h required 0/100000001",
               bus.m_pkt_metadata_psn, bus.m_flowstate_wr_data);
    end
    tick();
  endtask

  task automatic test_nondat_fallback();
    do_reset();
    drive(1'b1, 1'b0, 2'd0, 33'h1_0000_0040, 10'h040, 16'hE000);
    tick();
    checks++;
    if (bus.m_flowstate_wr_en !== 1'b0 || bus.m_pkt_metadata_psn !== 32'h40 ||
        bus.m_pkt_metadata_psn_valid !== 1'b0 || bus.m_pkt_metadata_valid !== 1'b1) begin
      errors++;
      $display("FAIL nondat: wr_en=%b psn=%h psn_valid=%b m_valid=%b required 0/40/0/1",
               bus.m_flowstate_wr_en, bus.m_pkt_metadata_psn, bus.m_pkt_metadata_psn_valid,
               bus.m_pkt_metadata_valid);
    end
    drive(1'b1, 1'b1, 2'd1, 33'h1_0000_0050, 10'h041, 16'hE001);
    tick();
    checks++;
    if (bus.m_pkt_metadata_psn !== 32'h50 || bus.m_pkt_metadata_psn_valid !== 1'b1 ||
        bus.m_flowstate_wr_data !== 33'h1_0000_0051) begin
      errors++;
      $display("FAIL fallback: psn=%h psn_valid=%b data=%h required 50/1/100000051",
               bus.m_pkt_metadata_psn, bus.m_pkt_metadata_psn_valid, bus.m_flowstate_wr_data);
    end
    drive(1'b0, 1'b1, 2'd0, 33'h0_0000_0060, 10'h042, 16'hE002);
    tick();
    idle();
    checks++;
    if (bus.m_flowstate_wr_en !== 1'b0 || bus.m_pkt_metadata_psn !== 32'h60 ||
        bus.m_pkt_metadata_psn_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss: wr_en=%b psn=%h psn_valid=%b required 0/60/0",
               bus.m_flowstate_wr_en, bus.m_pkt_metadata_psn, bus.m_pkt_metadata_psn_valid);
    end
`ifdef FLOWSTATE_WB_STATS_EN
    checks++;
    if (stat_wr_cnt !== 32'd1 || stat_fwd_cnt !== 32'd0 || stat_fwd_err_cnt !== 32'd1) begin
      errors++;
      $display("FAIL fallback_stats: wr=%0d fwd=%0d err=%0d required 1/0/1",
               stat_wr_cnt, stat_fwd_cnt, stat_fwd_err_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    bus.m_pkt_metadata_ready = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 33'h1_0000_0007, 10'h030, 16'hF000);
    tick();
    if (bus.m_flowstate_wr_en === 1'b1) pulses++;
    checks++;
    if (bus.m_pkt_metadata_valid !== 1'b1 || bus.m_pkt_metadata_psn !== 32'h7 ||
        bus.s_pkt_metadata_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: m_valid=%b psn=%h s_ready=%b required 1/7/0",
               bus.m_pkt_metadata_valid, bus.m_pkt_metadata_psn, bus.s_pkt_metadata_ready);
    end
    drive(1'b1, 1'b1, 2'd0, 33'h1_0000_0070, 10'h031, 16'hF001);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.m_flowstate_wr_en === 1'b1) pulses++;
      checks++;
      if (bus.s_pkt_metadata_ready !== 1'b0 || bus.m_pkt_metadata_valid !== 1'b1 ||
          bus.m_pkt_metadata_psn !== 32'h7 || bus.m_pkt_metadata_info[15:0] !== 16'hF000) begin
        errors++;
        $display("FAIL bp_hold_%0d: s_ready=%b m_valid=%b psn=%h tag=%h required 0/1/7/f000",
                 i, bus.s_pkt_metadata_ready, bus.m_pkt_metadata_valid,
                 bus.m_pkt_metadata_psn, bus.m_pkt_metadata_info[15:0]);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bp_wr_pulses: got %0d required 1", pulses);
    end
    rst = 1'b1;
    idle();
    tick();
    checks++;
    if (bus.m_pkt_metadata_valid !== 1'b0 || bus.m_flowstate_wr_en !== 1'b0 ||
        bus.m_pkt_metadata_psn !== 32'h0) begin
      errors++;
      $display("FAIL bp_reset: m_valid=%b wr_en=%b psn=%h required 0/0/0",
               bus.m_pkt_metadata_valid, bus.m_flowstate_wr_en, bus.m_pkt_metadata_psn);
    end
    rst = 1'b0;
    bus.m_pkt_metadata_ready = 1'b1;
    drive(1'b1, 1'b1, 2'd1, 33'h1_0000_0090, 10'h030, 16'hF002);
    tick();
    idle();
    checks++;
    if (bus.m_pkt_metadata_psn !== 32'h90 || bus.m_flowstate_wr_data !== 33'h1_0000_0091) begin
      errors++;
      $display("FAIL bp_hist_cleared: psn=%h data=%h required 90/100000091",
               bus.m_pkt_metadata_psn, bus.m_flowstate_wr_data);
    end
`ifdef FLOWSTATE_WB_STATS_EN
    checks++;
    if (stat_fwd_err_cnt !== 32'd1 || stat_wr_cnt !== 32'd1) begin
      errors++;
      $display("FAIL bp_stats: err=%0d wr=%0d required 1/1", stat_fwd_err_cnt, stat_wr_cnt);
    end
`endif
    tick();
  endtask

  initial begin
    bus.s_pkt_metadata_info      = '0;
    bus.s_pkt_metadata_match_sel = 2'd0;
    bus.s_pkt_metadata_mat_hit   = 1'b0;
    bus.s_pkt_metadata_mat_value = '0;
    bus.s_pkt_metadata_mat_addr  = '0;
    bus.s_pkt_metadata_valid     = 1'b0;
    bus.m_pkt_metadata_ready     = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_depth3();
    test_wrap();
    test_nondat_fallback();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flowstate_tx_update_wb.md
Name: flowstate_tx_update_wb

Overview:
- Consumer stage behind the flowstate tx address controller in the reliable-tx path.
- Takes packet metadata plus the flowstate match result (hit, value, addr, match_sel).
- Resolves read-after-write hazards by forwarding from its own 3-deep write history.
- Assigns the packet PSN, writes the incremented flowstate back to the flowstate table RAM, and forwards metadata plus assigned PSN downstream.

Parameters:
- PKT_METADATA_WIDTH, 274, width of packet metadata bus.
- FLOWSTATE_WIDTH, 33, flowstate entry width: [32] flow valid, [31:0] next PSN.
- ADDR_WIDTH, 10, flowstate table address width.
- PKT_PROPERTY_NO, 246, base bit of the packet property field in metadata; DAT tag is bit PKT_PROPERTY_NO+0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_pkt_metadata_info  in  PKT_METADATA_WIDTH  packet metadata
- s_pkt_metadata_match_sel  in  2  0 = use mat_value; 1/2/3 = forward from history entry 0/1/2
- s_pkt_metadata_mat_hit  in  1  flowstate lookup hit
- s_pkt_metadata_mat_value  in  FLOWSTATE_WIDTH  flowstate read from table
- s_pkt_metadata_mat_addr  in  ADDR_WIDTH  flowstate table address
- s_pkt_metadata_valid  in  1  input valid
- s_pkt_metadata_ready  out  1  input ready
- m_flowstate_wr_en  out  1  table write strobe
- m_flowstate_wr_addr  out  ADDR_WIDTH  write address
- m_flowstate_wr_data  out  FLOWSTATE_WIDTH  write data
- m_pkt_metadata_info  out  PKT_METADATA_WIDTH  registered metadata
- m_pkt_metadata_psn  out  32  PSN assigned to the packet
- m_pkt_metadata_psn_valid  out  1  PSN is meaningful (hit && DAT)
- m_pkt_metadata_valid  out  1  output valid
- m_pkt_metadata_ready  in  1  output ready

Behaviour:
- Accept condition: s_valid && s_ready.
- s_ready = ~m_valid || m_ready. It is not a function of s_valid.
- Old state (combinational) on accept:
  - sel=0: mat_value.
  - sel=1/2/3: hist_val[0/1/2], if that entry's valid bit is set.
  - If the selected entry is invalid, fall back to mat_value.
- do_write = mat_hit && metadata[PKT_PROPERTY_NO].
- On accept with do_write:
  - new_state = {1'b1, old[31:0]+1}, 32-bit modular increment (0xFFFFFFFF wraps to 0x00000000).
  - Next cycle: wr_en=1, wr_addr=mat_addr, wr_data=new_state.
  - Output psn = old[31:0], psn_valid=1.
- On accept without do_write:
  - No write.
  - Output psn = old[31:0], psn_valid=0.
- History push on every accept (3-entry shift, entry 0 newest), mirroring the controller's address history:
  - hist[0] <= {do_write, new_state}; hist[1] <= hist[0]; hist[2] <= hist[1].
  - Entry is invalid when no write occurs.
- The history update is registered, so the next accepted transaction, even back-to-back, sees it.
- Latency: 1 cycle from accept to m_valid and to wr_en.
- wr_en is a single-cycle pulse per write, independent of m_ready. The write is never stalled or repeated.
- m_valid holds with stable data while m_ready=0.
- Simultaneous m_ready and new accept: m_valid stays 1 and data is replaced.
- Reset:
  - m_valid=0, wr_en=0, wr_addr=0, wr_data=0, psn=0, psn_valid=0, all history valid bits=0.
  - m_pkt_metadata_info is not reset.
  - Reset mid-stream drops the held output and history. Upstream must be reset together with this block.

Optional Feature:
- FLOWSTATE_WB_STATS_EN. When defined, adds three saturating 32-bit output counters, cleared by rst:
  - stat_wr_cnt (writes).
  - stat_fwd_cnt (accepts with sel!=0 and a valid entry).
  - stat_fwd_err_cnt (sel!=0 pointing to an invalid entry).
- When undefined, these ports and logic are absent. Datapath behaviour is identical either way.

Decomposition:
- Shared package: flowstate field positions (valid bit 32, PSN [31:0]), DAT_TAG_INDEX=0, PKT_PROPERTY_NO, match_sel encodings.
- One sub-module: flowstate_wb_history, the 3-entry shift history with a combinational select port.

Test Plan:
- Single DAT hit, sel=0, mat_value=0x1_00000005, addr=0x010 -> psn=5, psn_valid=1; next cycle wr_en=1, wr_addr=0x010, wr_data=0x1_00000006.
- Back-to-back DAT hits to addr 0x010 with sel=1 on the 2nd and 3rd, stale mat_value=0x1_00000005 -> psn 5, 6, 7; writes 6, 7, 8.
- Forward from depth 3: writes to A, B, C, then A with sel=3 -> psn = A's last written PSN.
- Wrap: mat_value=0x1_FFFFFFFF -> psn=0xFFFFFFFF, wr_data=0x1_00000000.
- Non-DAT hit followed by sel=1 -> first transaction: no wr_en, psn_valid=0; second falls back to mat_value (and stat_fwd_err_cnt=1 when FLOWSTATE_WB_STATS_EN).
- Backpressure: m_ready=0 for 5 cycles -> s_ready=0 and output stable; a single wr_en pulse is seen. Assert rst mid-hold -> m_valid=0, history cleared.
